// File: rtl/param_reg_file.sv
// General-purpose register file: per-register load/clear/inc/dec under a shared
// function select and write mask, two combinational read ports, registered wrap flag.
module param_reg_file #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 8,
  parameter int SATURATE = 0,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [1:0]          i_fun_sel,
  input  logic [NUM_REGS-1:0] i_rsel,
  input  logic [WIDTH-1:0]    i_data,
  input  logic [SEL_W-1:0]    i_o1_sel,
  input  logic [SEL_W-1:0]    i_o2_sel,
  output logic [WIDTH-1:0]    o_o1,
  output logic [WIDTH-1:0]    o_o2,
  output logic                o_wrap
);

  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] FUN_CLR  = 2'b11;
  localparam int READ_SLOTS = 1 << SEL_W;

  logic [NUM_REGS-1:0][WIDTH-1:0]   r_regs;
  logic                             r_wrap;
  logic [NUM_REGS-1:0][WIDTH-1:0]   w_next;
  logic [NUM_REGS-1:0]              w_hit;
  logic [READ_SLOTS-1:0][WIDTH-1:0] w_read;
  logic                             w_inc;
  logic                             w_dec;

  assign w_inc = (i_fun_sel == FUN_INC);
  assign w_dec = (i_fun_sel == FUN_DEC);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic             w_at_max;
      logic             w_at_zero;
      logic [WIDTH-1:0] w_stepped;

      assign w_at_max  = &r_regs[gi];
      assign w_at_zero = ~|r_regs[gi];

      always_comb begin
        w_stepped = r_regs[gi];
        case (i_fun_sel)
          FUN_LOAD: w_stepped = i_data;
          FUN_CLR:  w_stepped = '0;
          FUN_INC: begin
            if (!(w_at_max && SATURATE != 0)) w_stepped = r_regs[gi] + 1'b1;
          end
          default: begin
            if (!(w_at_zero && SATURATE != 0)) w_stepped = r_regs[gi] - 1'b1;
          end
        endcase
      end

      assign w_next[gi] = i_rsel[gi] ? w_stepped : r_regs[gi];
      // A boundary hit counts whether it wrapped or clamped; unselected registers never count.
      assign w_hit[gi]  = i_rsel[gi] & ((w_inc & w_at_max) | (w_dec & w_at_zero));
    end

    // Pad the read mux to the full select range so out-of-range selects read zero.
    for (gi = 0; gi < READ_SLOTS; gi++) begin : g_read
      if (gi < NUM_REGS) begin : g_live
        assign w_read[gi] = r_regs[gi];
      end else begin : g_pad
        assign w_read[gi] = '0;
      end
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_regs <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_regs <= w_next;
      r_wrap <= |w_hit;
    end
  end

  assign o_o1   = w_read[i_o1_sel];
  assign o_o2   = w_read[i_o2_sel];
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file: wrap-mode and saturate-mode instances driven in lockstep
// and compared against a behavioural model of the register contents and wrap flag.
module tb_param_reg_file;

  logic       clk;
  logic       reset;
  logic [1:0] fun_sel;
  logic [3:0] rsel;
  logic [7:0] data;
  logic [2:0] o1_sel;
  logic [2:0] o2_sel;
  logic [7:0] o1_w, o2_w, o1_s, o2_s;
  logic       wrap_w, wrap_s;

  int total = 0;
  int bad   = 0;

  int mw[4];
  int ms[4];
  bit mwrap_w;
  bit mwrap_s;

  param_reg_file #(.WIDTH(8), .NUM_REGS(4), .SATURATE(0), .SEL_W(3)) dut_w (
    .i_clock(clk), .i_reset(reset), .i_fun_sel(fun_sel), .i_rsel(rsel), .i_data(data),
    .i_o1_sel(o1_sel), .i_o2_sel(o2_sel), .o_o1(o1_w), .o_o2(o2_w), .o_wrap(wrap_w)
  );

  param_reg_file #(.WIDTH(8), .NUM_REGS(4), .SATURATE(1)) dut_s (
    .i_clock(clk), .i_reset(reset), .i_fun_sel(fun_sel), .i_rsel(rsel), .i_data(data),
    .i_o1_sel(o1_sel[1:0]), .i_o2_sel(o2_sel[1:0]), .o_o1(o1_s), .o_o2(o2_s), .o_wrap(wrap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next value of one register under one command, straight from the operation rules.
  function automatic int model_next(input int v, input int f, input int d, input bit sat,
                                    output bit hit);
    hit = 1'b0;
    case (f)
      2: return d;
      3: return 0;
      1: begin
        if (v == 255) begin
          hit = 1'b1;
          return sat ? 255 : 0;
        end
        return v + 1;
      end
      default: begin
        if (v == 0) begin
          hit = 1'b1;
          return sat ? 0 : 255;
        end
        return v - 1;
      end
    endcase
  endfunction

  // Drive one command, clock it in, advance the model, land 1ns after the edge.
  task automatic step(input bit rst, input logic [1:0] f, input logic [3:0] m, input logic [7:0] d);
    bit h;
    reset   = rst;
    fun_sel = f;
    rsel    = m;
    data    = d;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        mw[k] = 0;
        ms[k] = 0;
      end
      mwrap_w = 0;
      mwrap_s = 0;
    end else begin
      mwrap_w = 0;
      mwrap_s = 0;
      for (int k = 0; k < 4; k++) begin
        if (m[k]) begin
          mw[k] = model_next(mw[k], int'(f), int'(d), 1'b0, h);
          mwrap_w = mwrap_w | h;
          ms[k] = model_next(ms[k], int'(f), int'(d), 1'b1, h);
          mwrap_s = mwrap_s | h;
        end
      end
    end
    #1;
    reset = 1'b0;
    rsel  = 4'b0000;
  endtask

  task automatic peek(input int k, output logic [7:0] vw, output logic [7:0] vs);
    o1_sel = k[2:0];
    #1;
    vw = o1_w;
    vs = o1_s;
  endtask

  task automatic test_reset();
    step(1, 2'b10, 4'b1111, 8'h5A);
    step(1, 2'b01, 4'b1111, 8'h00);
    o1_sel = 3'd0;
    o2_sel = 3'd2;
    #1;
    total++;
    if (o1_w !== 8'h00 || o1_s !== 8'h00) begin
      bad++;
      $display("FAIL reset_o1 got w=%h s=%h want 00", o1_w, o1_s);
    end
    total++;
    if (o2_w !== 8'h00 || o2_s !== 8'h00) begin
      bad++;
      $display("FAIL reset_o2 got w=%h s=%h want 00", o2_w, o2_s);
    end
    total++;
    if (wrap_w !== 1'b0 || wrap_s !== 1'b0) begin
      bad++;
      $display("FAIL reset_wrap got w=%b s=%b want 0", wrap_w, wrap_s);
    end
    $display("reset: O1=%h O2=%h wrap=%b", o1_w, o2_w, wrap_w);
  endtask

  task automatic test_load();
    logic [7:0] vw, vs;
    logic [7:0] want [4];
    want[0] = 8'hAA; want[1] = 8'h00; want[2] = 8'hAA; want[3] = 8'h00;
    step(0, 2'b10, 4'b0101, 8'hAA);
    for (int k = 0; k < 4; k++) begin
      peek(k, vw, vs);
      total++;
      if (vw !== want[k] || vs !== want[k]) begin
        bad++;
        $display("FAIL load_r%0d got w=%h s=%h want %h", k, vw, vs, want[k]);
      end
    end
    $display("load: R0..R3 checked against AA/00/AA/00");
  endtask

  task automatic test_wrap();
    logic [7:0] vw, vs;
    step(0, 2'b10, 4'b1000, 8'hFF);
    step(0, 2'b01, 4'b1000, 8'h00);
    peek(3, vw, vs);
    total++;
    if (vw !== 8'h00 || wrap_w !== 1'b1) begin
      bad++;
      $display("FAIL wrap_inc got R3=%h wrap=%b want 00 1", vw, wrap_w);
    end
    step(0, 2'b00, 4'b1000, 8'h00);
    peek(3, vw, vs);
    total++;
    if (vw !== 8'hFF || wrap_w !== 1'b1) begin
      bad++;
      $display("FAIL wrap_dec got R3=%h wrap=%b want FF 1", vw, wrap_w);
    end
    total++;
    if (vs !== 8'(ms[3]) || wrap_s !== mwrap_s) begin
      bad++;
      $display("FAIL wrap_sat_side got R3=%h wrap=%b want %h %b", vs, wrap_s, 8'(ms[3]), mwrap_s);
    end
    $display("wrap: R3=%h wrap=%b", vw, wrap_w);
  endtask

  task automatic test_saturate();
    logic [7:0] vw, vs;
    step(0, 2'b10, 4'b0010, 8'hFF);
    step(0, 2'b01, 4'b0010, 8'h00);
    peek(1, vw, vs);
    total++;
    if (vs !== 8'hFF || wrap_s !== 1'b1) begin
      bad++;
      $display("FAIL sat_inc got R1=%h wrap=%b want FF 1", vs, wrap_s);
    end
    step(0, 2'b11, 4'b0010, 8'h00);
    total++;
    if (wrap_s !== 1'b0) begin
      bad++;
      $display("FAIL sat_clear_wrap got %b want 0", wrap_s);
    end
    step(0, 2'b00, 4'b0010, 8'h00);
    peek(1, vw, vs);
    total++;
    if (vs !== 8'h00 || wrap_s !== 1'b1) begin
      bad++;
      $display("FAIL sat_dec got R1=%h wrap=%b want 00 1", vs, wrap_s);
    end
    $display("saturate: R1=%h wrap=%b", vs, wrap_s);
  endtask

  task automatic test_back_to_back();
    step(0, 2'b11, 4'b0001, 8'h00);
    step(0, 2'b00, 4'b0001, 8'h00);
    total++;
    if (wrap_w !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got %b want 1", wrap_w);
    end
    step(0, 2'b01, 4'b0001, 8'h00);
    total++;
    if (wrap_w !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got %b want 1", wrap_w);
    end
    step(0, 2'b01, 4'b0000, 8'h00);
    total++;
    if (wrap_w !== 1'b0 || wrap_s !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle got w=%b s=%b want 0", wrap_w, wrap_s);
    end
    $display("back_to_back: wrap after idle=%b", wrap_w);
  endtask

  task automatic test_collision();
    step(0, 2'b10, 4'b0100, 8'h10);
    o1_sel  = 3'd2;
    o2_sel  = 3'd2;
    fun_sel = 2'b10;
    rsel    = 4'b0100;
    data    = 8'h20;
    #1;
    total++;
    if (o1_w !== 8'h10 || o2_w !== 8'h10) begin
      bad++;
      $display("FAIL coll_before got O1=%h O2=%h want 10", o1_w, o2_w);
    end
    step(0, 2'b10, 4'b0100, 8'h20);
    total++;
    if (o1_w !== 8'h20 || o2_w !== 8'h20 || o1_s !== 8'h20) begin
      bad++;
      $display("FAIL coll_after got O1=%h O2=%h want 20", o1_w, o2_w);
    end
    $display("collision: O1=%h O2=%h", o1_w, o2_w);
  endtask

  task automatic test_out_of_range();
    step(0, 2'b10, 4'b1111, 8'h77);
    for (int s = 4; s < 8; s++) begin
      o2_sel = 3'(s);
      #1;
      total++;
      if (o2_w !== 8'h00) begin
        bad++;
        $display("FAIL oor_sel%0d got %h want 00", s, o2_w);
      end
    end
    o2_sel = 3'd1;
    #1;
    total++;
    if (o2_w !== 8'h77) begin
      bad++;
      $display("FAIL oor_inrange got %h want 77", o2_w);
    end
    $display("out_of_range: sel1 reads %h", o2_w);
  endtask

  task automatic test_reset_mid();
    logic [7:0] vw, vs;
    step(0, 2'b10, 4'b0001, 8'hFF);
    step(1, 2'b01, 4'b0001, 8'h00);
    peek(0, vw, vs);
    total++;
    if (vw !== 8'h00 || vs !== 8'h00 || wrap_w !== 1'b0 || wrap_s !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got R0=%h/%h wrap=%b/%b want 00 0", vw, vs, wrap_w, wrap_s);
    end
    $display("reset_mid: R0=%h wrap=%b", vw, wrap_w);
  endtask

  task automatic test_masking();
    logic [7:0] vw, vs;
    step(0, 2'b11, 4'b0001, 8'h00);
    step(0, 2'b10, 4'b0010, 8'h05);
    step(0, 2'b00, 4'b0010, 8'h00);
    total++;
    if (wrap_w !== 1'b0) begin
      bad++;
      $display("FAIL mask_wrap got %b want 0", wrap_w);
    end
    peek(1, vw, vs);
    total++;
    if (vw !== 8'h04) begin
      bad++;
      $display("FAIL mask_r1 got %h want 04", vw);
    end
    peek(0, vw, vs);
    total++;
    if (vw !== 8'h00) begin
      bad++;
      $display("FAIL mask_r0 got %h want 00", vw);
    end
    $display("masking: R0=%h wrap=%b", vw, wrap_w);
  endtask

  task automatic test_random();
    logic [7:0] vw, vs;
    logic [1:0] f;
    logic [3:0] m;
    logic [7:0] d;
    bit         r;
    int         errs_before;
    for (int n = 0; n < 150; n++) begin
      errs_before = bad;
      r = ($urandom_range(0, 15) == 0);
      f = 2'($urandom_range(0, 3));
      m = 4'($urandom_range(0, 15));
      // Bias loads toward the boundaries so wrap events are frequent.
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'hFF;
        default: d = 8'($urandom_range(0, 255));
      endcase
      step(r, f, m, d);
      total++;
      if (wrap_w !== mwrap_w || wrap_s !== mwrap_s) begin
        bad++;
        $display("FAIL rand%0d_wrap got w=%b s=%b want %b %b", n, wrap_w, wrap_s, mwrap_w, mwrap_s);
      end
      for (int k = 0; k < 4; k++) begin
        peek(k, vw, vs);
        total++;
        if (vw !== 8'(mw[k]) || vs !== 8'(ms[k])) begin
          bad++;
          $display("FAIL rand%0d_r%0d got w=%h s=%h want %h %h", n, k, vw, vs, 8'(mw[k]), 8'(ms[k]));
        end
      end
      o2_sel = 3'($urandom_range(0, 7));
      #1;
      total++;
      if (o2_w !== ((o2_sel < 3'd4) ? 8'(mw[o2_sel[1:0]]) : 8'h00)) begin
        bad++;
        $display("FAIL rand%0d_o2 sel=%0d got %h", n, o2_sel, o2_w);
      end
      $display("rand %0d: rst=%b fun=%b rsel=%b I=%h wrap=%b/%b %s", n, r, f, m, d,
               wrap_w, wrap_s, (bad == errs_before) ? "ok" : "bad");
    end
  endtask

  initial begin
    reset   = 1'b1;
    fun_sel = 2'b00;
    rsel    = 4'b0000;
    data    = 8'h00;
    o1_sel  = 3'd0;
    o2_sel  = 3'd0;
    for (int k = 0; k < 4; k++) begin
      mw[k] = 0;
      ms[k] = 0;
    end
    mwrap_w = 0;
    mwrap_s = 0;
    test_reset();
    test_load();
    test_wrap();
    test_saturate();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_reset_mid();
    test_masking();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_reg_file.md
# param_reg_file

Parametrised general-purpose register file for the CPU datapath, generalising the fixed 8-bit register and 4+4 register file to arbitrary width and depth. Each register supports load, clear, increment and decrement under a shared function select, with a multi-register write mask. Two independent combinational read ports feed the operand muxes and ALU. A registered per-cycle wrap flag and a saturating mode handle counter use, such as loop counters and stack pointers.

## Interface
- WIDTH, 8, bits per register (≥2)
- NUM_REGS, 8, number of registers (2..16)
- SATURATE, 0, 0: increment/decrement wrap modulo 2^WIDTH; 1: clamp at all-ones/zero
- SEL_W, $clog2(NUM_REGS), read-select width (derived; do not override)

- Clock  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; clears all registers and Wrap
- FunSel  in  2  00 decrement, 01 increment, 10 load I, 11 clear
- RSel  in  NUM_REGS  write-enable mask; bit k enables register k; multiple bits allowed
- I  in  WIDTH  load data
- O1Sel  in  SEL_W  read port 1 select
- O2Sel  in  SEL_W  read port 2 select
- O1  out  WIDTH  contents of register O1Sel
- O2  out  WIDTH  contents of register O2Sel
- Wrap  out  1  registered; high for one cycle after an inc/dec overflowed or underflowed (or clamped, in SATURATE mode) in any enabled register

## Operation
- State: NUM_REGS registers R[0..NUM_REGS-1], each WIDTH bits, plus the Wrap flop.
- The register update on each rising Clock edge follows a priority order:
  - Reset=1: all R[k] ← 0 and Wrap ← 0. RSel and FunSel are ignored.
  - Otherwise, for each k with RSel[k]=1, per FunSel:
    - 10: R[k] ← I.
    - 11: R[k] ← 0.
    - 01: R[k] ← R[k]+1. At all-ones, the result is 0 (wrap mode) or all-ones (SATURATE=1).
    - 00: R[k] ← R[k]−1. At 0, the result is all-ones (wrap mode) or 0 (SATURATE=1).
  - Registers with RSel[k]=0 hold their value.
- Arithmetic is unsigned, at WIDTH bits. No carry or borrow is stored beyond the Wrap flag.
- Wrap ← 1 if, in the same cycle, any enabled register hit a boundary:
  - FunSel=01 with R[k] all-ones, or
  - FunSel=00 with R[k]=0.
  - In all other cases Wrap ← 0. Load and clear never set Wrap.
  - RSel=0 on a boundary register produces no Wrap.
- Reads are combinational from current register state:
  - O1 = R[O1Sel] and O2 = R[O2Sel].
  - A select ≥ NUM_REGS drives all-zero.
  - Both ports may select the same register.
- When a register is read and written in the same cycle, the read returns the pre-edge value; there is no write-through bypass.
- RSel all-zero is a valid no-op for registers and forces Wrap ← 0 next cycle.

## Timing
- Reset values: every R[k]=0, Wrap=0. This makes O1=O2=0 one edge after Reset is sampled high.
- Write latency is 1 cycle: a new value is visible on O1/O2 after the rising edge that samples the command.
- Read latency is 0 cycles: combinational from select and state.
- Wrap asserts in the cycle following the offending edge's command and lasts exactly one cycle unless re-triggered. Back-to-back boundary events hold Wrap high continuously.
- Reset asserted mid-sequence, including in the same cycle as a load or increment, wins. Nothing other than zeroing takes effect.
- Inputs must be stable around the rising edge; there is no handshake and no stall.

## Test plan
All scenarios use WIDTH=8, NUM_REGS=4 unless stated.

- **Reset and load:**
  - Stimulus: Reset=1 for 2 cycles, then FunSel=10, RSel=0101, I=0xAA.
  - Required: before the load edge O1Sel=0/O2Sel=2 read 0x00. After it, R0=R2=0xAA and R1=R3=0x00; O1Sel=1 reads 0x00.
- **Wrap mode increment/decrement:**
  - Stimulus: load R3=0xFF, then increment R3, then decrement R3.
  - Required: R3 goes to 0x00 with Wrap=1 for the next cycle, then to 0xFF with Wrap=1 again.
- **Saturate mode** (SATURATE=1):
  - Stimulus: load R1=0xFF and increment; clear R1 and decrement.
  - Required: R1 stays 0xFF then 0x00, and Wrap pulses after each of the two boundary edges.
- **Read/write collision and dual read:**
  - Stimulus: with O1Sel=O2Sel=2 and R2=0x10, load I=0x20 into R2.
  - Required: both ports show 0x10 before the edge and 0x20 after it.
  - Stimulus: O2Sel=5 with NUM_REGS=4, SEL_W=3.
  - Required: O2 reads 0x00.
- **Reset mid-operation:**
  - Stimulus: R0=0xFF, then drive FunSel=01, RSel=0001 with Reset=1 on the same edge.
  - Required: R0=0x00, and Wrap=0 on the next cycle.
- **Masking:**
  - Stimulus: R0=0x00 and R1=0x05; decrement with RSel=0010.
  - Required: R1=0x04, R0 unchanged, Wrap=0 even though R0 sits at the boundary.
